// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer
//   Runs one register-file operation at a time through READ, EXEC and WRITE.
//   An operation is accepted in IDLE on a valid/ready handshake. Its operands
//   are read through the two combinational read ports and the ALU result is
//   written back through the single write port. Writes to ZERO_REG and NOPs
//   do not assert the write enable.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   op_valid/op_ready   operation handshake
//   op_code/op_src1/op_src2/op_dst/op_imm   operation fields
//   rf_src1/rf_src2     register file read addresses
//   rf_regA/rf_regB     register file read data
//   rf_dst/rf_data/rf_write   register file write port
//   done                one-cycle completion pulse (the WRITE cycle)
//   result/carry/zero   last ALU result and its flags
module regfile_op_sequencer #(
    parameter int unsigned SRCSIZE  = 2,
    parameter int unsigned ZERO_REG = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [2:0]         op_code,
    input  logic [SRCSIZE-1:0] op_src1,
    input  logic [SRCSIZE-1:0] op_src2,
    input  logic [SRCSIZE-1:0] op_dst,
    input  logic [7:0]         op_imm,
    output logic [SRCSIZE-1:0] rf_src1,
    output logic [SRCSIZE-1:0] rf_src2,
    input  logic [7:0]         rf_regA,
    input  logic [7:0]         rf_regB,
    output logic [SRCSIZE-1:0] rf_dst,
    output logic [7:0]         rf_data,
    output logic               rf_write,
    output logic               done,
    output logic [7:0]         result,
    output logic               carry,
    output logic               zero
);

    localparam int unsigned DW = 8;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MOV = 3'd5;
    localparam logic [2:0] OP_LDI = 3'd6;
    localparam logic [2:0] OP_NOP = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t             state;
    logic [2:0]         code_q;
    logic [SRCSIZE-1:0] src1_q;
    logic [SRCSIZE-1:0] src2_q;
    logic [SRCSIZE-1:0] dst_q;
    logic [DW-1:0]      imm_q;
    logic [DW-1:0]      opa_q;
    logic [DW-1:0]      opb_q;
    logic [DW-1:0]      result_q;
    logic               carry_q;
    logic               zero_q;
    logic               rf_write_q;
    logic               done_q;

    logic [DW-1:0]      alu_res_c;
    logic               alu_carry_c;
    logic [DW:0]        sum_c;
    logic [DW:0]        diff_c;

    // ALU on the latched operands; carry is the 9th sum bit or the borrow
    always_comb begin
        alu_res_c   = '0;
        alu_carry_c = 1'b0;
        sum_c       = {1'b0, opa_q} + {1'b0, opb_q};
        diff_c      = {1'b0, opa_q} - {1'b0, opb_q};
        case (code_q)
            OP_ADD: begin
                alu_res_c   = sum_c[DW-1:0];
                alu_carry_c = sum_c[DW];
            end
            OP_SUB: begin
                alu_res_c   = diff_c[DW-1:0];
                alu_carry_c = diff_c[DW];
            end
            OP_AND:  alu_res_c = opa_q & opb_q;
            OP_OR:   alu_res_c = opa_q | opb_q;
            OP_XOR:  alu_res_c = opa_q ^ opb_q;
            OP_MOV:  alu_res_c = opa_q;
            OP_LDI:  alu_res_c = imm_q;
            default: alu_res_c = result_q;
        endcase
    end

    // Sequencer FSM with registered write enable and completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            code_q     <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            dst_q      <= '0;
            imm_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            rf_write_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rf_write_q <= 1'b0;
            done_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        code_q <= op_code;
                        src1_q <= op_src1;
                        src2_q <= op_src2;
                        dst_q  <= op_dst;
                        imm_q  <= op_imm;
                        state  <= READ;
                    end
                end
                READ: begin
                    opa_q <= rf_regA;
                    opb_q <= rf_regB;
                    state <= EXEC;
                end
                EXEC: begin
                    // NOP leaves result and flags untouched
                    if (code_q != OP_NOP) begin
                        result_q <= alu_res_c;
                        carry_q  <= alu_carry_c;
                        zero_q   <= (alu_res_c == '0);
                    end
                    rf_write_q <= (code_q != OP_NOP) &&
                                  (dst_q != SRCSIZE'(ZERO_REG));
                    done_q     <= 1'b1;
                    state      <= WRITE;
                end
                WRITE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign op_ready = (state == IDLE) && !rst;
    assign rf_src1  = src1_q;
    assign rf_src2  = src2_q;
    assign rf_dst   = dst_q;
    assign rf_data  = result_q;
    assign rf_write = rf_write_q;
    assign done     = done_q;
    assign result   = result_q;
    assign carry    = carry_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Bench for regfile_op_sequencer: behavioural register file, a reference model
// that predicts each operation at issue time, and a done-triggered scoreboard.
module tb_regfile_op_sequencer;

    localparam int unsigned SRCSIZE = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               op_valid;
    logic               op_ready;
    logic [2:0]         op_code;
    logic [SRCSIZE-1:0] op_src1, op_src2, op_dst;
    logic [7:0]         op_imm;
    logic [SRCSIZE-1:0] rf_src1, rf_src2, rf_dst;
    logic [7:0]         rf_regA, rf_regB, rf_data;
    logic               rf_write, done, carry, zero;
    logic [7:0]         result;

    regfile_op_sequencer #(.SRCSIZE(2), .ZERO_REG(3)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_src1(op_src1), .op_src2(op_src2), .op_dst(op_dst), .op_imm(op_imm),
        .rf_src1(rf_src1), .rf_src2(rf_src2),
        .rf_regA(rf_regA), .rf_regB(rf_regB),
        .rf_dst(rf_dst), .rf_data(rf_data), .rf_write(rf_write),
        .done(done), .result(result), .carry(carry), .zero(zero)
    );

    always #5 clk = ~clk;

    // Register file: combinational reads, register 3 reads as zero
    logic [7:0] mem [4];
    assign rf_regA = (rf_src1 == 2'd3) ? 8'h00 : mem[rf_src1];
    assign rf_regB = (rf_src2 == 2'd3) ? 8'h00 : mem[rf_src2];
    always @(posedge clk) if (rf_write) mem[rf_dst] <= rf_data;

    typedef struct {
        logic [1:0] dst;
        logic [7:0] res;
        logic       carry;
        logic       zero;
        logic       wr;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ref_regs [4];
    logic [7:0] ref_result;
    logic       ref_carry, ref_zero;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         hs_q[$];

    always @(posedge clk) begin
        if (!rst && op_valid && op_ready) hs_q.push_back(cyc);
        cyc <= cyc + 1;
    end

    // Scoreboard: every done pulse retires the oldest prediction
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_unexpected_done got done=1 required no pending op");
                    errors++;
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (rf_write !== e.wr) begin
                        $display("FAIL sb_rf_write got %0b required %0b", rf_write, e.wr);
                        errors++;
                    end
                    checks++;
                    if (rf_dst !== e.dst) begin
                        $display("FAIL sb_rf_dst got %0d required %0d", rf_dst, e.dst);
                        errors++;
                    end
                    checks++;
                    if (rf_data !== e.res || result !== e.res) begin
                        $display("FAIL sb_result got data=%h result=%h required %h", rf_data, result, e.res);
                        errors++;
                    end
                    checks++;
                    if (carry !== e.carry || zero !== e.zero) begin
                        $display("FAIL sb_flags got c=%0b z=%0b required c=%0b z=%0b", carry, zero, e.carry, e.zero);
                        errors++;
                    end
                    checks++;
                end
            end else if (rf_write) begin
                $display("FAIL sb_write_without_done got rf_write=1 required 0");
                errors++;
                checks++;
            end
        end
    end

    function automatic logic [7:0] ref_rd(input logic [1:0] r);
        return (r == 2'd3) ? 8'h00 : ref_regs[r];
    endfunction

    task automatic predict(input logic [2:0] c, input logic [1:0] s1, input logic [1:0] s2,
                           input logic [1:0] d, input logic [7:0] imm);
        exp_t       e;
        logic [7:0] a, b;
        logic [8:0] s;
        a = ref_rd(s1);
        b = ref_rd(s2);
        case (c)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; ref_result = s[7:0]; ref_carry = s[8]; end
            3'd1: begin ref_result = a - b; ref_carry = (a < b); end
            3'd2: begin ref_result = a & b; ref_carry = 1'b0; end
            3'd3: begin ref_result = a | b; ref_carry = 1'b0; end
            3'd4: begin ref_result = a ^ b; ref_carry = 1'b0; end
            3'd5: begin ref_result = a;     ref_carry = 1'b0; end
            3'd6: begin ref_result = imm;   ref_carry = 1'b0; end
            default: ;
        endcase
        if (c != 3'd7) ref_zero = (ref_result == 8'h00);
        e.wr    = (c != 3'd7) && (d != 2'd3);
        if (e.wr) ref_regs[d] = ref_result;
        e.dst   = d;
        e.res   = ref_result;
        e.carry = ref_carry;
        e.zero  = ref_zero;
        sb.push_back(e);
    endtask

    // Drive one operation and return just after its handshake edge
    task automatic issue(input logic [2:0] c, input logic [1:0] s1, input logic [1:0] s2,
                         input logic [1:0] d, input logic [7:0] imm,
                         input bit keep_valid, input bit expect_it);
        int n = 0;
        @(negedge clk);
        op_code = c; op_src1 = s1; op_src2 = s2; op_dst = d; op_imm = imm;
        op_valid = 1'b1;
        while (!op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) begin
            $display("FAIL issue_timeout got op_ready=0 required 1 within 20 cycles");
            errors++;
            checks++;
        end
        if (expect_it) predict(c, s1, s2, d, imm);
        @(posedge clk);
        #1;
        if (!keep_valid) op_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !op_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0 || !op_ready) begin
            $display("FAIL wait_idle_timeout got pending=%0d op_ready=%0b required 0/1", sb.size(), op_ready);
            errors++;
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (op_ready !== 1'b0 || rf_write !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_ctrl got ready=%0b wr=%0b done=%0b required 0/0/0", op_ready, rf_write, done);
            errors++;
        end
        checks++;
        if (result !== 8'h00 || carry !== 1'b0 || zero !== 1'b0) begin
            $display("FAIL reset_alu got result=%h c=%0b z=%0b required 00/0/0", result, carry, zero);
            errors++;
        end
        checks++;
        if (rf_dst !== 2'd0 || rf_data !== 8'h00 || rf_src1 !== 2'd0 || rf_src2 !== 2'd0) begin
            $display("FAIL reset_rf_ports got dst=%0d data=%h s1=%0d s2=%0d required zeros", rf_dst, rf_data, rf_src1, rf_src2);
            errors++;
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (op_ready !== 1'b1) begin
            $display("FAIL reset_release_ready got %0b required 1", op_ready);
            errors++;
        end
    endtask

    task automatic test_ldi_add();
        logic [2:0] codes [3];
        logic [1:0] dsts [3];
        logic [7:0] imms [3];
        int         lat;
        codes[0] = 3'd6; dsts[0] = 2'd0; imms[0] = 8'hF0;
        codes[1] = 3'd6; dsts[1] = 2'd1; imms[1] = 8'h20;
        codes[2] = 3'd0; dsts[2] = 2'd2; imms[2] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            issue(codes[i], 2'd0, 2'd1, dsts[i], imms[i], 1'b0, 1'b1);
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!done && lat < 10);
            checks++;
            if (lat != 3) begin
                $display("FAIL ldi_add_latency op%0d got %0d required 3", i, lat);
                errors++;
            end
            wait_idle();
        end
        checks++;
        if (mem[2] !== 8'h10 || carry !== 1'b1 || zero !== 1'b0) begin
            $display("FAIL ldi_add_r2 got r2=%h c=%0b z=%0b required 10/1/0", mem[2], carry, zero);
            errors++;
        end
    endtask

    task automatic test_sub();
        issue(3'd6, 2'd0, 2'd0, 2'd0, 8'h05, 1'b0, 1'b1); wait_idle();
        issue(3'd6, 2'd0, 2'd0, 2'd1, 8'h07, 1'b0, 1'b1); wait_idle();
        issue(3'd1, 2'd0, 2'd1, 2'd2, 8'h00, 1'b0, 1'b1); wait_idle();
        checks++;
        if (result !== 8'hFE || carry !== 1'b1) begin
            $display("FAIL sub_borrow got result=%h c=%0b required FE/1", result, carry);
            errors++;
        end
        issue(3'd1, 2'd1, 2'd1, 2'd2, 8'h00, 1'b0, 1'b1); wait_idle();
        checks++;
        if (result !== 8'h00 || carry !== 1'b0 || zero !== 1'b1) begin
            $display("FAIL sub_zero got result=%h c=%0b z=%0b required 00/0/1", result, carry, zero);
            errors++;
        end
    endtask

    task automatic test_zero_reg_nop();
        issue(3'd6, 2'd0, 2'd0, 2'd3, 8'h55, 1'b0, 1'b1); wait_idle();
        checks++;
        if (result !== 8'h55 || mem[3] !== 8'h00) begin
            $display("FAIL zero_reg got result=%h r3=%h required 55/00", result, mem[3]);
            errors++;
        end
        issue(3'd7, 2'd0, 2'd1, 2'd1, 8'h99, 1'b0, 1'b1); wait_idle();
        checks++;
        if (result !== 8'h55 || mem[1] !== 8'h07) begin
            $display("FAIL nop_hold got result=%h r1=%h required 55/07", result, mem[1]);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        hs_q.delete();
        issue(3'd6, 2'd0, 2'd0, 2'd0, 8'hAA, 1'b1, 1'b1);
        issue(3'd5, 2'd0, 2'd0, 2'd1, 8'h00, 1'b1, 1'b1);
        issue(3'd4, 2'd0, 2'd1, 2'd2, 8'h00, 1'b1, 1'b1);
        issue(3'd3, 2'd0, 2'd2, 2'd2, 8'h00, 1'b0, 1'b1);
        wait_idle();
        checks++;
        if (hs_q.size() != 4) begin
            $display("FAIL b2b_handshakes got %0d required 4", hs_q.size());
            errors++;
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (hs_q[i] - hs_q[i-1] != 4) begin
                    $display("FAIL b2b_spacing %0d got %0d required 4", i, hs_q[i] - hs_q[i-1]);
                    errors++;
                end
            end
        end
        checks++;
        if (mem[1] !== 8'hAA || mem[2] !== 8'hAA) begin
            $display("FAIL b2b_dependent got r1=%h r2=%h required AA/AA", mem[1], mem[2]);
            errors++;
        end
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] prior_r2;
        bit         saw_write = 1'b0;
        issue(3'd6, 2'd0, 2'd0, 2'd1, 8'h11, 1'b0, 1'b1); wait_idle();
        prior_r2 = mem[2];
        issue(3'd0, 2'd0, 2'd1, 2'd2, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (rf_write !== 1'b0 || done !== 1'b0 || op_ready !== 1'b0) begin
            $display("FAIL abort_async got wr=%0b done=%0b ready=%0b required 0/0/0", rf_write, done, op_ready);
            errors++;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rf_write || done) saw_write = 1'b1;
        end
        rst = 1'b0;
        ref_result = 8'h00; ref_carry = 1'b0; ref_zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rf_write || done) saw_write = 1'b1;
        end
        checks++;
        if (saw_write || mem[2] !== prior_r2) begin
            $display("FAIL abort_no_write got saw=%0b r2=%h required 0/%h", saw_write, mem[2], prior_r2);
            errors++;
        end
        issue(3'd0, 2'd0, 2'd1, 2'd2, 8'h00, 1'b0, 1'b1); wait_idle();
        checks++;
        if (mem[2] !== ref_regs[2]) begin
            $display("FAIL abort_recover got r2=%h required %h", mem[2], ref_regs[2]);
            errors++;
        end
    endtask

    initial begin
        op_valid = 1'b0; op_code = '0; op_src1 = '0; op_src2 = '0; op_dst = '0; op_imm = '0;
        for (int i = 0; i < 4; i++) begin
            mem[i] = 8'h00;
            ref_regs[i] = 8'h00;
        end
        ref_result = 8'h00; ref_carry = 1'b0; ref_zero = 1'b0;
        test_reset();
        test_ldi_add();
        test_sub();
        test_zero_reg_nop();
        test_back_to_back();
        test_reset_mid_op();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
